cv32e40p_jtag_dtm_driver: RTL and testbench

// - JTAG initiator: turns IR/DR scan requests into TCK/TMS/TDI waveforms for the cv32e40p debug TAP, captures TDO.
// - Replaces hand-toggled JTAG pins in FPGA benches and on-board self-test; sits between a host/command FSM and the TAP pins.
// - One scan per request; shifted-out TDO bits returned on a response handshake.

---
 rtl/cv32e40p_jtag_drv_pkg.sv | 25 ++
 rtl/cv32e40p_jtag_tck_gen.sv | 38 +++
 rtl/cv32e40p_jtag_dtm_driver.sv | 176 +++++++++++++++++
 tb/tb_cv32e40p_jtag_dtm_driver.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_jtag_drv_pkg.sv
// Shared constants for the cv32e40p JTAG DTM driver: FSM encodings,
// TAP header TMS patterns and the Test-Logic-Reset walk length.
package cv32e40p_jtag_drv_pkg;

  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_TLR_SEQ = 3'd2;
  localparam logic [2:0] ST_HDR     = 3'd3;
  localparam logic [2:0] ST_SHIFT   = 3'd4;
  localparam logic [2:0] ST_TRAIL   = 3'd5;
  localparam logic [2:0] ST_RSP     = 3'd6;

  // TMS header patterns, bit 0 goes out first (Run-Test/Idle -> Shift-xR)
  localparam int         HDR_LEN_DR = 3;
  localparam int         HDR_LEN_IR = 4;
  localparam logic [3:0] HDR_TMS_DR = 4'b0001;
  localparam logic [3:0] HDR_TMS_IR = 4'b0011;

  localparam int TLR_LEN = 5;

  function automatic logic [3:0] hdr_tms(input logic is_ir);
    return is_ir ? HDR_TMS_IR : HDR_TMS_DR;
  endfunction

endpackage

// File: rtl/cv32e40p_jtag_tck_gen.sv
// TCK divider: low phase first, CLK_DIV clk per half period, with one-clk
// strobes on the clk where tck rises (rise_tick) and where it falls (fall_tick).
module cv32e40p_jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tck,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int CW = $clog2(2 * CLK_DIV);

  logic [CW-1:0] cnt;

  assign rise_tick = enable && (cnt == CW'(CLK_DIV - 1));
  assign fall_tick = enable && (cnt == CW'(2 * CLK_DIV - 1));

  // Disabling parks tck low and restarts the next period at its low phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!enable) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (fall_tick) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (rise_tick) tck <= 1'b1;
    end
  end

endmodule

// File: rtl/cv32e40p_jtag_dtm_driver.sv
// JTAG initiator for the cv32e40p debug TAP: one IR/DR scan per request.
// Define JTAG_DRV_TLR_INIT_EN to walk the TAP through Test-Logic-Reset after reset.
module cv32e40p_jtag_dtm_driver
  import cv32e40p_jtag_drv_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_is_ir_i,
  input  logic [LEN_W-1:0]   req_len_i,
  input  logic [MAX_LEN-1:0] req_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i,
  output logic               trst_no,
  output logic               busy_o
);

  logic [2:0]         state;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_c;
  logic [LEN_W-1:0]   hdr_last;
  logic               is_ir_q;
  logic [3:0]         hdr_q;
  logic [3:0]         hdr_sel;
  logic [MAX_LEN-1:0] sh_q;
  logic [MAX_LEN-1:0] mask_q;
  logic [MAX_LEN-1:0] cap_q;
  logic               tck_en;
  logic               fall_tick;
  logic               rise_tick;

  assign len_c       = (req_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : req_len_i;
  assign hdr_sel     = hdr_tms(req_is_ir_i);
  assign hdr_last    = is_ir_q ? LEN_W'(HDR_LEN_IR - 1) : LEN_W'(HDR_LEN_DR - 1);
  assign tck_en      = state inside {ST_TLR_SEQ, ST_HDR, ST_SHIFT, ST_TRAIL};
  assign req_ready_o = (state == ST_IDLE);
  assign busy_o      = (state != ST_IDLE);
  assign rsp_data_o  = cap_q;

  cv32e40p_jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk       (clk_i),
    .rst       (rst_i),
    .enable    (tck_en),
    .tck       (tck_o),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

  // TMS/TDI advance on fall_tick (start of low phase), TDO is taken on rise_tick
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_INIT;
      cnt         <= '0;
      len_q       <= '0;
      is_ir_q     <= 1'b0;
      hdr_q       <= '0;
      sh_q        <= '0;
      mask_q      <= '0;
      cap_q       <= '0;
      rsp_valid_o <= 1'b0;
      tms_o       <= 1'b1;
      tdi_o       <= 1'b0;
      trst_no     <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          trst_no <= 1'b1;
          cnt     <= '0;
`ifdef JTAG_DRV_TLR_INIT_EN
          state   <= ST_TLR_SEQ;
          tms_o   <= 1'b1;
`else
          state   <= ST_IDLE;
          tms_o   <= 1'b0;
`endif
        end

        ST_IDLE: begin
          if (req_valid_i) begin
            is_ir_q <= req_is_ir_i;
            len_q   <= len_c;
            hdr_q   <= hdr_sel;
            sh_q    <= req_data_i;
            mask_q  <= {{(MAX_LEN - 1){1'b0}}, 1'b1};
            cap_q   <= '0;
            cnt     <= '0;
            if (len_c == '0) begin
              state <= ST_RSP;
            end else begin
              state <= ST_HDR;
              tms_o <= hdr_sel[0];
            end
          end
        end

        ST_TLR_SEQ: begin
          if (fall_tick) begin
            if (cnt == LEN_W'(TLR_LEN)) begin
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
              if (cnt == LEN_W'(TLR_LEN - 1)) tms_o <= 1'b0;
            end
          end
        end

        ST_HDR: begin
          if (fall_tick) begin
            if (cnt == hdr_last) begin
              state <= ST_SHIFT;
              cnt   <= '0;
              tms_o <= (len_q == LEN_W'(1));
              tdi_o <= sh_q[0];
            end else begin
              cnt   <= cnt + 1'b1;
              hdr_q <= hdr_q >> 1;
              tms_o <= hdr_q[1];
            end
          end
        end

        ST_SHIFT: begin
          if (rise_tick && tdo_i) cap_q <= cap_q | mask_q;
          if (fall_tick) begin
            if (cnt == len_q - LEN_W'(1)) begin
              state <= ST_TRAIL;
              cnt   <= '0;
              tms_o <= 1'b1;
              tdi_o <= 1'b0;
            end else begin
              cnt    <= cnt + 1'b1;
              sh_q   <= sh_q >> 1;
              mask_q <= mask_q << 1;
              tdi_o  <= sh_q[1];
              tms_o  <= (cnt + LEN_W'(2) == len_q);
            end
          end
        end

        ST_TRAIL: begin
          if (fall_tick) begin
            if (cnt == '0) begin
              cnt   <= LEN_W'(1);
              tms_o <= 1'b0;
            end else begin
              state <= ST_RSP;
            end
          end
        end

        ST_RSP: begin
          if (!rsp_valid_o) begin
            rsp_valid_o <= 1'b1;
          end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40p_jtag_dtm_driver.sv
// Bench for cv32e40p_jtag_dtm_driver with a 5-bit-IR TAP model (IDCODE 0x1E200A6D).
// Building with JTAG_DRV_TLR_INIT_EN runs at CLK_DIV=1 and adds the TLR walk scenario.
module tb_cv32e40p_jtag_dtm_driver;

  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;
`ifdef JTAG_DRV_TLR_INIT_EN
  localparam int DIV = 1;
`else
  localparam int DIV = 2;
`endif
  localparam logic [31:0] IDCODE    = 32'h1E200A6D;
  localparam logic [4:0]  IR_IDCODE = 5'h01;

  logic               clk       = 1'b0;
  logic               rst       = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_is_ir = 1'b0;
  logic [LEN_W-1:0]   req_len   = '0;
  logic [MAX_LEN-1:0] req_data  = '0;
  logic               rsp_ready = 1'b0;
  logic               tdo       = 1'b0;
  logic               req_ready;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               tck;
  logic               tms;
  logic               tdi;
  logic               trst_n;
  logic               busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int tck_rises    = 0;
  int tlr_base     = 0;
  logic tms_log [0:1023];

  cv32e40p_jtag_dtm_driver #(.CLK_DIV(DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_is_ir_i (req_is_ir),
    .req_len_i   (req_len),
    .req_data_i  (req_data),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .tck_o       (tck),
    .tms_o       (tms),
    .tdi_o       (tdi),
    .tdo_i       (tdo),
    .trst_no     (trst_n),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SEL_DR, T_CAP_DR, T_SH_DR, T_EX1_DR, T_PA_DR, T_EX2_DR, T_UPD_DR,
    T_SEL_IR, T_CAP_IR, T_SH_IR, T_EX1_IR, T_PA_IR, T_EX2_IR, T_UPD_IR
  } tap_t;

  tap_t        tap_state = T_RTI;
  logic [4:0]  ir        = IR_IDCODE;
  logic [4:0]  ir_sh     = '0;
  logic [31:0] dr_id     = '0;
  logic        byp       = 1'b0;
  logic        saw_tlr   = 1'b0;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      T_TLR:    return m ? T_TLR    : T_RTI;
      T_RTI:    return m ? T_SEL_DR : T_RTI;
      T_SEL_DR: return m ? T_SEL_IR : T_CAP_DR;
      T_CAP_DR: return m ? T_EX1_DR : T_SH_DR;
      T_SH_DR:  return m ? T_EX1_DR : T_SH_DR;
      T_EX1_DR: return m ? T_UPD_DR : T_PA_DR;
      T_PA_DR:  return m ? T_EX2_DR : T_PA_DR;
      T_EX2_DR: return m ? T_UPD_DR : T_SH_DR;
      T_UPD_DR: return m ? T_SEL_DR : T_RTI;
      T_SEL_IR: return m ? T_TLR    : T_CAP_IR;
      T_CAP_IR: return m ? T_EX1_IR : T_SH_IR;
      T_SH_IR:  return m ? T_EX1_IR : T_SH_IR;
      T_EX1_IR: return m ? T_UPD_IR : T_PA_IR;
      T_PA_IR:  return m ? T_EX2_IR : T_PA_IR;
      T_EX2_IR: return m ? T_UPD_IR : T_SH_IR;
      default:  return m ? T_SEL_DR : T_RTI;
    endcase
  endfunction

  // TRST parks the model in Run-Test/Idle with IDCODE selected, so trst_no
  // alone leaves it ready for the driver's header sequence.
  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tap_state <= T_RTI;
      ir        <= IR_IDCODE;
    end else begin
      case (tap_state)
        T_TLR:    begin ir <= IR_IDCODE; saw_tlr <= 1'b1; end
        T_CAP_DR: begin dr_id <= IDCODE; byp <= 1'b0; end
        T_SH_DR:  begin dr_id <= {tdi, dr_id[31:1]}; byp <= tdi; end
        T_CAP_IR: ir_sh <= 5'b00001;
        T_SH_IR:  ir_sh <= {tdi, ir_sh[4:1]};
        T_UPD_IR: ir <= ir_sh;
        default:  ;
      endcase
      tap_state <= tap_next(tap_state, tms);
    end
  end

  always @(negedge tck) begin
    if (tap_state == T_SH_DR)      tdo <= (ir == IR_IDCODE) ? dr_id[0] : byp;
    else if (tap_state == T_SH_IR) tdo <= ir_sh[0];
    else                           tdo <= 1'b0;
  end

  always @(posedge tck) begin
    if (tck_rises < 1024) tms_log[tck_rises] = tms;
    tck_rises = tck_rises + 1;
  end

  // Issues one request and waits for rsp_valid; lat counts clk edges after the accept edge
  task automatic do_scan(input logic is_ir, input logic [LEN_W-1:0] len,
                         input logic [MAX_LEN-1:0] data, output int lat, output logic ok);
    int w;
    ok  = 1'b0;
    lat = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_is_ir = is_ir;
    req_len   = len;
    req_data  = data;
    w = 0;
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    ok = rsp_valid;
  endtask

  task automatic consume;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({req_ready, rsp_valid, tck, tms, tdi, trst_n, busy} !== 7'b0001001) begin
      tests_failed++;
      $display("[TB] FAIL reset_pins: got rdy/vld/tck/tms/tdi/trst/busy=%b expected 0001001",
               {req_ready, rsp_valid, tck, tms, tdi, trst_n, busy});
    end
    tests_run++;
    if (rsp_data !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rsp_data: got %h expected 0", rsp_data);
    end
    tlr_base = tck_rises;
    rst = 1'b0;
    @(negedge clk);
`ifdef JTAG_DRV_TLR_INIT_EN
    tests_run++;
    if ({trst_n, busy, req_ready} !== 3'b110) begin
      tests_failed++;
      $display("[TB] FAIL release_state: got trst/busy/rdy=%b expected 110", {trst_n, busy, req_ready});
    end
`else
    tests_run++;
    if ({trst_n, busy, req_ready, tms} !== 4'b1010) begin
      tests_failed++;
      $display("[TB] FAIL release_state: got trst/busy/rdy/tms=%b expected 1010",
               {trst_n, busy, req_ready, tms});
    end
`endif
  endtask

`ifdef JTAG_DRV_TLR_INIT_EN
  task automatic test_tlr_init;
    int w;
    logic [5:0] seq;
    w = 0;
    while (!req_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    tests_run++;
    if (tck_rises - tlr_base !== 6 || !req_ready) begin
      tests_failed++;
      $display("[TB] FAIL tlr_cycles: got %0d tck cycles ready=%b expected 6 ready=1",
               tck_rises - tlr_base, req_ready);
    end
    for (int i = 0; i < 6; i++) seq[i] = tms_log[tlr_base + i];
    tests_run++;
    if (seq !== 6'b011111) begin
      tests_failed++;
      $display("[TB] FAIL tlr_tms_seq: got %b expected 011111", seq);
    end
    tests_run++;
    if (tap_state !== T_RTI || !saw_tlr) begin
      tests_failed++;
      $display("[TB] FAIL tlr_tap_state: got %0d saw_tlr=%b expected %0d saw_tlr=1",
               tap_state, saw_tlr, T_RTI);
    end
  endtask
`endif

  task automatic test_dr_idcode;
    int lat;
    int base;
    logic ok;
    base = tck_rises;
    do_scan(1'b0, 7'd32, 64'h0, lat, ok);
    tests_run++;
    if (!ok || rsp_data !== {32'h0, IDCODE}) begin
      tests_failed++;
      $display("[TB] FAIL dr_idcode_data: got %h (valid=%b) expected %h", rsp_data, ok, {32'h0, IDCODE});
    end
    tests_run++;
    if (lat !== (3 + 32 + 2) * 2 * DIV + 1) begin
      tests_failed++;
      $display("[TB] FAIL dr_idcode_latency: got %0d expected %0d", lat, (3 + 32 + 2) * 2 * DIV + 1);
    end
    tests_run++;
    if (tck_rises - base !== 37 || tap_state !== T_RTI || tck !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL dr_idcode_tap: got %0d tck cycles state %0d tck=%b expected 37 state %0d tck=0",
               tck_rises - base, tap_state, tck, T_RTI);
    end
    consume();
  endtask

  task automatic test_len_clamp;
    int lat;
    logic ok;
    do_scan(1'b0, 7'd100, 64'h0000_0000_0000_00F0, lat, ok);
    tests_run++;
    if (!ok || rsp_data !== 64'h0000_00F0_1E20_0A6D) begin
      tests_failed++;
      $display("[TB] FAIL clamp_data: got %h expected 000000f01e200a6d", rsp_data);
    end
    tests_run++;
    if (lat !== (3 + 64 + 2) * 2 * DIV + 1 || tap_state !== T_RTI) begin
      tests_failed++;
      $display("[TB] FAIL clamp_latency: got %0d state %0d expected %0d state %0d",
               lat, tap_state, (3 + 64 + 2) * 2 * DIV + 1, T_RTI);
    end
    consume();
  endtask

  task automatic test_len_zero;
    int lat;
    int base;
    logic ok;
    base = tck_rises;
    do_scan(1'b1, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, lat, ok);
    tests_run++;
    if (!ok || lat !== 1 || rsp_data !== 64'h0 || tck_rises !== base) begin
      tests_failed++;
      $display("[TB] FAIL len_zero: got lat=%0d data=%h tck cycles=%0d expected lat=1 data=0 cycles=0",
               lat, rsp_data, tck_rises - base);
    end
    consume();
  endtask

  task automatic test_ir_scan;
    int lat;
    int base;
    logic ok;
    logic [10:0] seq;
    base = tck_rises;
    do_scan(1'b1, 7'd5, 64'h11, lat, ok);
    tests_run++;
    if (!ok || rsp_data !== 64'h01) begin
      tests_failed++;
      $display("[TB] FAIL ir_capture: got %h expected 1", rsp_data);
    end
    tests_run++;
    if (ir !== 5'h11 || tap_state !== T_RTI) begin
      tests_failed++;
      $display("[TB] FAIL ir_update: got ir=%h state %0d expected ir=11 state %0d", ir, tap_state, T_RTI);
    end
    for (int i = 0; i < 11; i++) seq[i] = tms_log[base + i];
    tests_run++;
    if (tck_rises - base !== 11 || seq !== 11'h303) begin
      tests_failed++;
      $display("[TB] FAIL ir_tms_seq: got %0d cycles seq %b expected 11 cycles seq 01100000011",
               tck_rises - base, seq);
    end
    tests_run++;
    if (lat !== (4 + 5 + 2) * 2 * DIV + 1) begin
      tests_failed++;
      $display("[TB] FAIL ir_latency: got %0d expected %0d", lat, (4 + 5 + 2) * 2 * DIV + 1);
    end
    consume();
  endtask

  task automatic test_rsp_stall;
    int lat;
    int bad;
    logic ok;
    do_scan(1'b0, 7'd8, 64'hA5, lat, ok);
    tests_run++;
    if (!ok || rsp_data !== 64'h4A || lat !== (3 + 8 + 2) * 2 * DIV + 1) begin
      tests_failed++;
      $display("[TB] FAIL bypass_scan: got %h lat=%0d expected 4a lat=%0d",
               rsp_data, lat, (3 + 8 + 2) * 2 * DIV + 1);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== 64'h4A || req_ready !== 1'b0 || tck !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL stall_hold: got %0d unstable cycles expected 0", bad);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    tests_run++;
    if ({req_ready, rsp_valid, busy} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL stall_release: got rdy/vld/busy=%b expected 100", {req_ready, rsp_valid, busy});
    end
  endtask

  task automatic test_reset_mid_scan;
    int lat;
    int base;
    int w;
    logic ok;
    @(negedge clk);
    req_valid = 1'b1;
    req_is_ir = 1'b0;
    req_len   = 7'd32;
    req_data  = 64'h0;
    w = 0;
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    base = tck_rises;
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (tck_rises - base < 14 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    tests_run++;
    if (tck_rises - base !== 14) begin
      tests_failed++;
      $display("[TB] FAIL midscan_reach: got %0d tck cycles expected 14", tck_rises - base);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({tck, tms, trst_n, rsp_valid, busy} !== 5'b01001) begin
      tests_failed++;
      $display("[TB] FAIL midscan_reset: got tck/tms/trst/vld/busy=%b expected 01001",
               {tck, tms, trst_n, rsp_valid, busy});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_scan(1'b0, 7'd32, 64'h0, lat, ok);
    tests_run++;
    if (!ok || rsp_data !== {32'h0, IDCODE} || tap_state !== T_RTI) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_idcode: got %h state %0d expected %h state %0d",
               rsp_data, tap_state, {32'h0, IDCODE}, T_RTI);
    end
    consume();
  endtask

  initial begin
    test_reset();
`ifdef JTAG_DRV_TLR_INIT_EN
    test_tlr_init();
`endif
    test_dr_idcode();
    test_len_clamp();
    test_len_zero();
    test_ir_scan();
    test_rsp_stall();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
